// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feeder: FSM encoding and the
// drain length needed to push the last skewed pair through the array.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // The last pair needs rows+cols cycles to reach the far corner PE.
   function automatic int flush_len(input int rows, input int cols);
      return rows + cols;
   endfunction

endpackage

// File: rtl/skew_delay.sv
// Fixed-length shift register for one feeder lane; output is the last stage.
module skew_delay #(
   parameter int DW    = 8,
   parameter int DEPTH = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] stage_q [DEPTH];
   logic [DW-1:0] stage_d [DEPTH];

   always_comb begin
      stage_d[0] = din;
      for (int k = 1; k < DEPTH; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   // NOTE: every stage is reset because a stale word left in a lane after an
   // aborted job would be multiplied into the next job's accumulators.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking so each stage samples its neighbour's old value.
         for (int k = 0; k < DEPTH; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Feeds skewed A columns / B rows into a ROW_len x COL_len systolic array,
// clears its accumulators at job start and flags when results are final.
module systolic_feeder
   import systolic_pkg::*;
#(
   parameter int ROW_len = 3,
   parameter int COL_len = 3,
   parameter int DW      = 8,
   parameter int KW      = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ROW_len*DW-1:0]  a_vec,
   input  logic [COL_len*DW-1:0]  b_vec,
   output logic [ROW_len*DW-1:0]  a_bus,
   output logic [COL_len*DW-1:0]  b_bus,
   output logic                   acc_clr,
   output logic                   busy,
   output logic                   done
);

   localparam int FLUSH_LEN = flush_len(ROW_len, COL_len);
   localparam int FW        = $clog2(FLUSH_LEN + 1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LEN - 1);

   state_t          state_q, state_d;
   logic [KW-1:0]   k_len_q, k_len_d;
   logic [KW-1:0]   k_cnt_q, k_cnt_d;
   logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
   logic            acc_clr_q, acc_clr_d;

   logic            accept;
   logic            xfer;
   logic            last_xfer;
   logic [ROW_len*DW-1:0] a_lane_in;
   logic [COL_len*DW-1:0] b_lane_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         k_len_q     <= '0;
         k_cnt_q     <= '0;
         flush_cnt_q <= '0;
         acc_clr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_len_q     <= k_len_d;
         k_cnt_q     <= k_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         acc_clr_q   <= acc_clr_d;
      end
   end

   assign accept    = (state_q == IDLE) && start;
   assign xfer      = in_valid && (state_q == FEED);
   assign last_xfer = xfer && ((k_cnt_q + KW'(1)) == k_len_q);

   always_comb begin
      // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (k_len == '0) ? DONE : FEED;
         FEED:    if (last_xfer) state_d = FLUSH;
         FLUSH:   if (flush_cnt_q == FLUSH_LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      k_len_d     = k_len_q;
      k_cnt_d     = k_cnt_q;
      flush_cnt_d = '0;
      acc_clr_d   = accept;
      if (accept) begin
         k_len_d = k_len;
         k_cnt_d = '0;
      end else if (xfer) begin
         k_cnt_d = k_cnt_q + KW'(1);
      end
      if (state_q == FLUSH) begin
         flush_cnt_d = flush_cnt_q + FW'(1);
      end
   end

   always_comb begin
      in_ready = (state_q == FEED);
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      acc_clr  = acc_clr_q;
   end

   // Non-transfer slots feed zeros on both edges so A/B stay paired.
   assign a_lane_in = xfer ? a_vec : '0;
   assign b_lane_in = xfer ? b_vec : '0;

   for (genvar g = 0; g < ROW_len + COL_len; g++) begin : g_lane
      if (g < ROW_len) begin : g_a
         skew_delay #(
            .DW    (DW),
            .DEPTH (g + 1)
         ) u_dly (
            .clk  (clk),
            .rst  (rst),
            .din  (a_lane_in[g*DW +: DW]),
            .dout (a_bus[g*DW +: DW])
         );
      end else begin : g_b
         localparam int J = g - ROW_len;
         skew_delay #(
            .DW    (DW),
            .DEPTH (J + 1)
         ) u_dly (
            .clk  (clk),
            .rst  (rst),
            .din  (b_lane_in[J*DW +: DW]),
            .dout (b_bus[J*DW +: DW])
         );
      end
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter ROW_len, default 3: number of array rows (A lanes).
REQ-002 SHALL have parameter COL_len, default 3: number of array columns (B lanes).
REQ-003 SHALL have parameter DW, default 8: signed A/B element width.
REQ-004 SHALL have parameter KW, default 8: width of the K-length count.
REQ-005 SHALL have port clk  input  1: the single clock, rising edge.
REQ-006 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1: one-cycle job request.
REQ-008 SHALL have port k_len  input  KW: number of A/B vector pairs in the job, sampled on accepted start.
REQ-009 SHALL have port in_valid  input  1: a_vec/b_vec valid.
REQ-010 SHALL have port in_ready  output  1: feeder accepts a vector pair.
REQ-011 SHALL have port a_vec  input  ROW_len*DW: one A column, lane i at [(i+1)*DW-1 -: DW].
REQ-012 SHALL have port b_vec  input  COL_len*DW: one B row, lane j at [(j+1)*DW-1 -: DW].
REQ-013 SHALL have port a_bus  output  ROW_len*DW: skewed A stream to the array's left edge.
REQ-014 SHALL have port b_bus  output  COL_len*DW: skewed B stream to the array's top edge.
REQ-015 SHALL have port acc_clr  output  1: one-cycle pulse that clears array accumulators.
REQ-016 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-017 SHALL have port done  output  1: one-cycle pulse; array results are final.

Function
REQ-018 SHALL implement FSM states IDLE, FEED, FLUSH and DONE.
REQ-019 In IDLE, start SHALL latch k_len, pulse acc_clr in the next cycle, and go to FEED, or to DONE if k_len==0.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 in_ready SHALL equal (state==FEED).
REQ-022 A transfer SHALL occur when in_valid&&in_ready; each transfer SHALL increment the K counter.
REQ-023 On the transfer that reaches k_len, the FSM SHALL go to FEED->FLUSH.
REQ-024 A-lane i SHALL appear on a_bus exactly i+1 cycles after its transfer; B-lane j SHALL appear on b_bus exactly j+1 cycles after its transfer.
REQ-025 Each lane delay SHALL be a per-lane shift register.
REQ-026 In any cycle without a transfer (FEED bubble, FLUSH, IDLE, DONE), zeros SHALL enter every lane's delay line.
REQ-027 Bubbles SHALL NOT disturb A/B pairing: both streams carry zero for that slot.
REQ-028 FLUSH SHALL last exactly ROW_len+COL_len cycles, then go to DONE.
REQ-029 done SHALL therefore rise exactly ROW_len+COL_len+1 cycles after the final transfer.
REQ-030 DONE SHALL last one cycle, with done=1, then return to IDLE.
REQ-031 Data SHALL pass through unmodified: no arithmetic, no width change, signed values preserved.
REQ-032 The K counter SHALL be KW bits and SHALL NOT wrap within a job (k_len ≤ 2^KW-1).

Reset
REQ-033 rst high SHALL asynchronously force state IDLE, K counter 0, all delay registers 0, and a_bus=0, b_bus=0, in_ready=0, acc_clr=0, busy=0, done=0.
REQ-034 rst asserted mid-job SHALL abort the job; no done SHALL follow.
REQ-035 After release, the block SHALL accept start on the first clk edge.

Structure
REQ-036 The FSM state encoding SHALL live in a shared package, systolic_pkg, together with the FLUSH length expression.
REQ-037 The per-lane delay SHALL be one sub-module, skew_delay, parameterised by DW and DEPTH, instantiated ROW_len+COL_len times in a generate loop.

Verification
REQ-038 Single pair: k_len=1, a_vec={3,2,1}, b_vec={6,5,4} -> a_bus lanes 0/1/2 show 1/2/3 at T+1/T+2/T+3, b_bus lanes show 4/5/6 likewise, done at T+7.
REQ-039 Full 3x3 matmul, with the feeder driving a 3x3 array whose accumulators are cleared by acc_clr: A=[[1,2,3],[4,5,6],[7,8,9]], B=identity, k_len=3 -> at done, c_bus equals A.
REQ-040 Bubbles: the same job with in_valid deasserted for 2 cycles between pairs -> identical c_bus, with done delayed by 2 cycles.
REQ-041 k_len=0 -> acc_clr pulse and done pulse with no FEED state; a_bus/b_bus remain 0.
REQ-042 rst asserted in FLUSH -> all outputs 0 immediately, no done; a new start afterwards completes normally.
REQ-043 start pulsed while busy -> ignored; k_len is not re-latched and the done count is unchanged.
